// File: rtl/wave_synth_core.sv
// wave_synth_core: sample datapath behind the waveform control block.
// Two phase accumulators (wave and noise) feed a four-register pipeline:
// capture on the tick, raw wave/noise selection, signed gain scaling with
// saturation, then an optional saturating sum into the output sample.
// Sine values come from an external synchronous two-port ROM addressed
// directly by the live phase registers.
module wave_synth_core #(
  parameter int                SIZE_WIDTH     = 24,
  parameter int                SIZE_DEPTH     = 1024,
  parameter int                NUM_MODE_WAVE  = 3,
  parameter int                NUM_DUTY_CYCLE = 3,
  parameter int                SIZE_GAIN_WAVE = 3,
  parameter logic [23:0]       LFSR_SEED      = 24'hACE1B5,
  localparam int               PW             = $clog2(SIZE_DEPTH)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_tick,
  input  logic [NUM_MODE_WAVE-1:0]         i_sel_wave,
  input  logic [NUM_DUTY_CYCLE-1:0]        i_sel_duty_cycle,
  input  logic signed [SIZE_GAIN_WAVE-1:0] i_gain_wave,
  input  logic [PW-1:0]                    i_phase_step_wave,
  input  logic                             i_add_noise,
  input  logic                             i_lfsr_sin,
  input  logic [PW-1:0]                    i_phase_step_noise,
  input  logic signed [SIZE_GAIN_WAVE-1:0] i_gain_noise,
  output logic [PW-1:0]                    o_rom_addr_a,
  input  logic signed [SIZE_WIDTH-1:0]     i_rom_data_a,
  output logic [PW-1:0]                    o_rom_addr_b,
  input  logic signed [SIZE_WIDTH-1:0]     i_rom_data_b,
  output logic signed [SIZE_WIDTH-1:0]     o_sample,
  output logic                             o_valid
);

  localparam int PROD_W = SIZE_WIDTH + SIZE_GAIN_WAVE;

  // Galois feedback mask for x^24 + x^23 + x^22 + x^17 + 1 (right-shifting form)
  localparam logic [23:0] LFSR_MASK = 24'hE10000;

  localparam logic signed [SIZE_WIDTH-1:0] S_MAX     = {1'b0, {(SIZE_WIDTH-1){1'b1}}};
  localparam logic signed [SIZE_WIDTH-1:0] S_MIN     = {1'b1, {(SIZE_WIDTH-1){1'b0}}};
  localparam logic signed [SIZE_WIDTH-1:0] S_NEG_MAX = {1'b1, {(SIZE_WIDTH-2){1'b0}}, 1'b1};

  localparam logic [NUM_MODE_WAVE-1:0] WAVE_SINE     = NUM_MODE_WAVE'(0);
  localparam logic [NUM_MODE_WAVE-1:0] WAVE_SQUARE   = NUM_MODE_WAVE'(1);
  localparam logic [NUM_MODE_WAVE-1:0] WAVE_TRIANGLE = NUM_MODE_WAVE'(2);
  localparam logic [NUM_MODE_WAVE-1:0] WAVE_SAW      = NUM_MODE_WAVE'(3);

  localparam logic [NUM_DUTY_CYCLE-1:0] DUTY_10 = NUM_DUTY_CYCLE'(0);
  localparam logic [NUM_DUTY_CYCLE-1:0] DUTY_25 = NUM_DUTY_CYCLE'(1);
  localparam logic [NUM_DUTY_CYCLE-1:0] DUTY_50 = NUM_DUTY_CYCLE'(2);
  localparam logic [NUM_DUTY_CYCLE-1:0] DUTY_75 = NUM_DUTY_CYCLE'(3);
  localparam logic [NUM_DUTY_CYCLE-1:0] DUTY_90 = NUM_DUTY_CYCLE'(4);

  localparam logic [PW-1:0] THR_10 = PW'(102);
  localparam logic [PW-1:0] THR_25 = PW'(256);
  localparam logic [PW-1:0] THR_50 = PW'(512);
  localparam logic [PW-1:0] THR_75 = PW'(768);
  localparam logic [PW-1:0] THR_90 = PW'(922);

  // Multiply by the signed gain, divide by 4 with an arithmetic shift and
  // clamp to the sample range; only -full-scale times -4 can overflow.
  function automatic logic signed [SIZE_WIDTH-1:0] scale_sat(
    input logic signed [SIZE_WIDTH-1:0]     raw,
    input logic signed [SIZE_GAIN_WAVE-1:0] gain
  );
    logic signed [PROD_W-1:0]    prod;
    logic signed [PROD_W-1:0]    shifted;
    logic [PROD_W-SIZE_WIDTH:0]  top;
    prod    = PROD_W'(raw) * PROD_W'(gain);
    shifted = prod >>> 2;
    top     = shifted[PROD_W-1:SIZE_WIDTH-1];
    if (!top[PROD_W-SIZE_WIDTH] && (|top)) begin
      return S_MAX;
    end else if (top[PROD_W-SIZE_WIDTH] && !(&top)) begin
      return S_MIN;
    end else begin
      return shifted[SIZE_WIDTH-1:0];
    end
  endfunction

  // Accumulator and LFSR state
  logic [PW-1:0]  phase_w;
  logic [PW-1:0]  phase_n;
  logic [23:0]    lfsr;
  logic [PW:0]    phase_n_sum;

  // Stage 1: values captured on the tick
  logic                             s1_valid;
  logic [PW-1:0]                    s1_phase_w;
  logic [23:0]                      s1_lfsr;
  logic [NUM_MODE_WAVE-1:0]         s1_sel_wave;
  logic [NUM_DUTY_CYCLE-1:0]        s1_duty;
  logic signed [SIZE_GAIN_WAVE-1:0] s1_gain_w;
  logic signed [SIZE_GAIN_WAVE-1:0] s1_gain_n;
  logic                             s1_add_noise;
  logic                             s1_lfsr_sin;

  // Stage 2: raw wave and noise
  logic                             s2_valid;
  logic signed [SIZE_WIDTH-1:0]     s2_raw_w;
  logic signed [SIZE_WIDTH-1:0]     s2_raw_n;
  logic signed [SIZE_GAIN_WAVE-1:0] s2_gain_w;
  logic signed [SIZE_GAIN_WAVE-1:0] s2_gain_n;
  logic                             s2_add_noise;

  // Stage 3: scaled wave and noise
  logic                             s3_valid;
  logic signed [SIZE_WIDTH-1:0]     s3_wave;
  logic signed [SIZE_WIDTH-1:0]     s3_noise;
  logic                             s3_add_noise;

  // Combinational helpers
  logic signed [SIZE_WIDTH-1:0] raw_w;
  logic signed [SIZE_WIDTH-1:0] raw_n;
  logic [PW-1:0]                thr;
  logic [PW-2:0]                tri_u;
  logic signed [SIZE_WIDTH:0]   sum_wide;
  logic signed [SIZE_WIDTH-1:0] sum_sat;

  // The ROM sees the live phases so its registered data lines up with stage 1
  assign o_rom_addr_a = phase_w;
  assign o_rom_addr_b = phase_n;

  assign phase_n_sum = {1'b0, phase_n} + {1'b0, i_phase_step_noise};

  // Advance both phase accumulators on each tick; the LFSR steps on a noise-phase wrap
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase_w <= '0;
      phase_n <= '0;
      lfsr    <= LFSR_SEED;
    end else if (i_tick) begin
      phase_w <= phase_w + i_phase_step_wave;
      phase_n <= phase_n_sum[PW-1:0];
      if (phase_n_sum[PW]) begin
        lfsr <= {1'b0, lfsr[23:1]} ^ (lfsr[0] ? LFSR_MASK : 24'h0);
      end
    end
  end

  // Capture the pre-update phase, LFSR and all controls so the sample is self-consistent
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid     <= 1'b0;
      s1_phase_w   <= '0;
      s1_lfsr      <= '0;
      s1_sel_wave  <= '0;
      s1_duty      <= '0;
      s1_gain_w    <= '0;
      s1_gain_n    <= '0;
      s1_add_noise <= 1'b0;
      s1_lfsr_sin  <= 1'b0;
    end else begin
      s1_valid <= i_tick;
      if (i_tick) begin
        s1_phase_w   <= phase_w;
        s1_lfsr      <= lfsr;
        s1_sel_wave  <= i_sel_wave;
        s1_duty      <= i_sel_duty_cycle;
        s1_gain_w    <= i_gain_wave;
        s1_gain_n    <= i_gain_noise;
        s1_add_noise <= i_add_noise;
        s1_lfsr_sin  <= i_lfsr_sin;
      end
    end
  end

  // Build the raw waveform from the captured phase and pick the noise source
  always_comb begin
    raw_w = '0;
    raw_n = '0;
    thr   = THR_50;
    tri_u = '0;
    case (s1_duty)
      DUTY_10: thr = THR_10;
      DUTY_25: thr = THR_25;
      DUTY_50: thr = THR_50;
      DUTY_75: thr = THR_75;
      DUTY_90: thr = THR_90;
      default: thr = THR_50;
    endcase
    tri_u = s1_phase_w[PW-1] ? ~s1_phase_w[PW-2:0] : s1_phase_w[PW-2:0];
    case (s1_sel_wave)
      WAVE_SINE:     raw_w = i_rom_data_a;
      WAVE_SQUARE:   raw_w = (s1_phase_w < thr) ? S_MAX : S_NEG_MAX;
      WAVE_TRIANGLE: raw_w = {~tri_u[PW-2], tri_u[PW-3:0], {(SIZE_WIDTH-PW+1){1'b0}}};
      WAVE_SAW:      raw_w = {~s1_phase_w[PW-1], s1_phase_w[PW-2:0], {(SIZE_WIDTH-PW){1'b0}}};
      default:       raw_w = '0;
    endcase
    raw_n = s1_lfsr_sin ? $signed(s1_lfsr) : i_rom_data_b;
  end

  // Register the raw wave and noise together with the gains they need next
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_valid     <= 1'b0;
      s2_raw_w     <= '0;
      s2_raw_n     <= '0;
      s2_gain_w    <= '0;
      s2_gain_n    <= '0;
      s2_add_noise <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_raw_w     <= raw_w;
        s2_raw_n     <= raw_n;
        s2_gain_w    <= s1_gain_w;
        s2_gain_n    <= s1_gain_n;
        s2_add_noise <= s1_add_noise;
      end
    end
  end

  // Apply the signed gains with saturation
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s3_valid     <= 1'b0;
      s3_wave      <= '0;
      s3_noise     <= '0;
      s3_add_noise <= 1'b0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_wave      <= scale_sat(s2_raw_w, s2_gain_w);
        s3_noise     <= scale_sat(s2_raw_n, s2_gain_n);
        s3_add_noise <= s2_add_noise;
      end
    end
  end

  // One extra bit holds the full sum; a sign/overflow-bit mismatch means clamp
  always_comb begin
    sum_wide = {s3_wave[SIZE_WIDTH-1], s3_wave} + {s3_noise[SIZE_WIDTH-1], s3_noise};
    sum_sat  = sum_wide[SIZE_WIDTH-1:0];
    if (sum_wide[SIZE_WIDTH] != sum_wide[SIZE_WIDTH-1]) begin
      sum_sat = sum_wide[SIZE_WIDTH] ? S_MIN : S_MAX;
    end
  end

  // Publish the final sample with a one-cycle valid pulse; the sample holds between updates
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sample <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= s3_valid;
      if (s3_valid) begin
        o_sample <= s3_add_noise ? sum_sat : s3_wave;
      end
    end
  end

endmodule
